// File: rtl/joypad_pkg.sv
// Shared definitions for the two-channel standard-controller port.
// Optional turbo generator is enabled by defining JOYPAD_TURBO_EN.
package joypad_pkg;

    localparam int unsigned JOYPAD_BITS = 8;
    localparam logic        JOYPAD_FILL = 1'b1;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } button_index;

endpackage

// File: rtl/joypad_port_if.sv
// GPIO-side bus between the CPU core ($4016/$4017) and the joypad port.
// master = core side, slave = joypad port side.
interface joypad_port_if;

    logic       I_strobe;
    logic [1:0] I_rden;
    logic [1:0] O_data;

    modport master (
        output I_strobe,
        output I_rden,
        input  O_data
    );

    modport slave (
        input  I_strobe,
        input  I_rden,
        output O_data
    );

endinterface

// File: rtl/joypad_shifter.sv
// One controller channel: button synchroniser, optional turbo gating,
// 8-bit parallel-load / serial-out latch with 1-fill.
// Turbo gating is built only when JOYPAD_TURBO_EN is defined.
module joypad_shifter
    import joypad_pkg::*;
(
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic                   I_strobe,
    input  logic                   I_rden,
    input  logic [JOYPAD_BITS-1:0] I_buttons,
`ifdef JOYPAD_TURBO_EN
    input  logic [1:0]             I_turbo,
    input  logic                   I_phase,
`endif
    output logic                   O_data
);

    logic [JOYPAD_BITS-1:0] btn_meta;
    logic [JOYPAD_BITS-1:0] sync_btn;
    logic [JOYPAD_BITS-1:0] eff_btn;
    logic [JOYPAD_BITS-1:0] shreg;
    logic                   last_rden;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            btn_meta <= '0;
            sync_btn <= '0;
        end else begin
            btn_meta <= I_buttons;
            sync_btn <= btn_meta;
        end
    end

`ifdef JOYPAD_TURBO_EN
    logic [1:0] turbo_meta;
    logic [1:0] sync_turbo;

    // Two-flop synchroniser for the asynchronous turbo enables.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            turbo_meta <= '0;
            sync_turbo <= '0;
        end else begin
            turbo_meta <= I_turbo;
            sync_turbo <= turbo_meta;
        end
    end
`endif

    // Effective buttons: turbo-enabled A/B read released during phase 1.
    always_comb begin
        eff_btn = sync_btn;
`ifdef JOYPAD_TURBO_EN
        eff_btn[BTN_A] = sync_btn[BTN_A] & ~(sync_turbo[0] & I_phase);
        eff_btn[BTN_B] = sync_btn[BTN_B] & ~(sync_turbo[1] & I_phase);
`endif
    end

    // Strobe load has priority; otherwise shift on the falling edge of rden
    // so the CPU samples the current bit before it moves.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            shreg     <= '0;
            last_rden <= 1'b0;
        end else begin
            last_rden <= I_rden;
            if (I_strobe) begin
                shreg <= eff_btn;
            end else if (last_rden && !I_rden) begin
                shreg <= {JOYPAD_FILL, shreg[JOYPAD_BITS-1:1]};
            end
        end
    end

    assign O_data = shreg[0];

endmodule

// File: rtl/joypad_port.sv
// Two-channel standard-controller serial port feeding the core GPIO inputs.
// Define JOYPAD_TURBO_EN to build the shared turbo counter/phase generator.
module joypad_port
    import joypad_pkg::*;
#(
    parameter logic [23:0] TURBO_HALF = 24'd894886
)(
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic [JOYPAD_BITS-1:0] I_buttons0,
    input  logic [JOYPAD_BITS-1:0] I_buttons1,
    input  logic [1:0]             I_turbo0,
    input  logic [1:0]             I_turbo1,
    joypad_port_if.slave           bus
);

    logic data0;
    logic data1;

`ifdef JOYPAD_TURBO_EN
    logic [23:0] turbo_cnt;
    logic        phase;

    // Free-running turbo counter; phase flips every TURBO_HALF cycles.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            turbo_cnt <= '0;
            phase     <= 1'b0;
        end else if (turbo_cnt == TURBO_HALF - 24'd1) begin
            turbo_cnt <= '0;
            phase     <= ~phase;
        end else begin
            turbo_cnt <= turbo_cnt + 24'd1;
        end
    end
`else
    logic unused_turbo;
    assign unused_turbo = ^{I_turbo0, I_turbo1, TURBO_HALF};
`endif

    joypad_shifter u_port0 (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .I_strobe  (bus.I_strobe),
        .I_rden    (bus.I_rden[0]),
        .I_buttons (I_buttons0),
`ifdef JOYPAD_TURBO_EN
        .I_turbo   (I_turbo0),
        .I_phase   (phase),
`endif
        .O_data    (data0)
    );

    joypad_shifter u_port1 (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .I_strobe  (bus.I_strobe),
        .I_rden    (bus.I_rden[1]),
        .I_buttons (I_buttons1),
`ifdef JOYPAD_TURBO_EN
        .I_turbo   (I_turbo1),
        .I_phase   (phase),
`endif
        .O_data    (data1)
    );

    assign bus.O_data = {data1, data0};

endmodule

// File: tb/tb_joypad_port.sv
// Scoreboard bench for joypad_port: stimulus pushes expected O_data values,
// a monitor pops and compares on every read start or explicit probe.
module tb_joypad_port;

    typedef struct {
        logic [1:0] exp;
        logic [1:0] mask;
        string      name;
    } item_t;

    logic       clk;
    logic       I_reset;
    logic [7:0] I_buttons0;
    logic [7:0] I_buttons1;
    logic [1:0] I_turbo0;
    logic [1:0] I_turbo1;
    logic       probe_req;
    logic [1:0] rden_q;

    item_t sb[$];
    int    checks;
    int    errors;

    // reference model: latched word and number of bits already read per port
    logic [7:0] m_word [2];
    int         m_cnt  [2];

    joypad_port_if bus ();

    joypad_port #(.TURBO_HALF(24'd4)) dut (
        .I_clock    (clk),
        .I_reset    (I_reset),
        .I_buttons0 (I_buttons0),
        .I_buttons1 (I_buttons1),
        .I_turbo0   (I_turbo0),
        .I_turbo1   (I_turbo1),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: a read starting (rden rising) or a probe presents an output
    initial rden_q = 2'b00;
    always @(negedge clk) begin
        logic  ev;
        item_t it;
        ev = probe_req || ((bus.I_rden & ~rden_q) != 2'b00);
        if (ev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: O_data=%b, no expected value queued", bus.O_data);
            end else begin
                it = sb.pop_front();
                if ((bus.O_data & it.mask) !== (it.exp & it.mask)) begin
                    errors++;
                    $display("FAIL %s: O_data=%b expected=%b (mask %b) at %0t",
                             it.name, bus.O_data, it.exp, it.mask, $time);
                end
            end
        end
        rden_q <= bus.I_rden;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] exp, input logic [1:0] mask, input string name);
        item_t it;
        it.exp  = exp;
        it.mask = mask;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic probe(input logic [1:0] exp, input logic [1:0] mask, input string name);
        push(exp, mask, name);
        probe_req = 1'b1;
        tick();
        probe_req = 1'b0;
    endtask

    // one CPU read pulse on port p; expected value sampled at the read start
    task automatic read(input int p, input logic [1:0] exp, input logic [1:0] mask,
                        input string name);
        push(exp, mask, name);
        bus.I_rden[p] = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        bus.I_rden[p] = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1, input int len);
        I_buttons0 = b0;
        I_buttons1 = b1;
        repeat (3) tick();
        bus.I_strobe = 1'b1;
        repeat (len) tick();
        bus.I_strobe = 1'b0;
        tick();
        m_word[0] = b0;
        m_word[1] = b1;
        m_cnt[0]  = 0;
        m_cnt[1]  = 0;
    endtask

    function automatic logic m_bit(input int p);
        return (m_cnt[p] < 8) ? m_word[p][m_cnt[p]] : 1'b1;
    endfunction

    initial begin
        logic [7:0] basic;
        logic       b;
        int         p;
        checks       = 0;
        errors       = 0;
        probe_req    = 1'b0;
        I_reset      = 1'b1;
        I_buttons0   = 8'hA5;
        I_buttons1   = 8'h5A;
        I_turbo0     = 2'b00;
        I_turbo1     = 2'b00;
        bus.I_strobe = 1'b0;
        bus.I_rden   = 2'b00;
        repeat (3) tick();
        I_reset = 1'b0;

        // reset state and reads before any strobe
        probe(2'b00, 2'b11, "reset_state");
        read(0, 2'b00, 2'b01, "post_reset_read0");
        read(1, 2'b00, 2'b10, "post_reset_read1");

        // basic serial read with 1-fill
        basic = 8'b1000_0101;
        load(basic, 8'h00, 4);
        for (int i = 0; i < 12; i++) begin
            b = (i < 8) ? basic[i] : 1'b1;
            read(0, {1'b0, b}, 2'b01, $sformatf("basic_bit%0d", i));
        end

        // strobe held high: O_data follows A with sync + load latency, no shift
        I_buttons0   = 8'h00;
        bus.I_strobe = 1'b1;
        repeat (3) tick();
        I_buttons0 = 8'h01;
        probe(2'b00, 2'b01, "strobe_lat0");
        probe(2'b00, 2'b01, "strobe_lat1");
        probe(2'b00, 2'b01, "strobe_lat2");
        probe(2'b01, 2'b01, "strobe_rise");
        for (int i = 0; i < 3; i++) read(0, 2'b01, 2'b01, "strobe_read");
        I_buttons0 = 8'h00;
        probe(2'b01, 2'b01, "strobe_fall_lat0");
        probe(2'b01, 2'b01, "strobe_fall_lat1");
        probe(2'b01, 2'b01, "strobe_fall_lat2");
        probe(2'b00, 2'b01, "strobe_fall");
        I_buttons0 = 8'h01;
        repeat (3) tick();
        bus.I_strobe = 1'b0;
        tick();
        read(0, 2'b01, 2'b01, "after_strobe_A");
        read(0, 2'b00, 2'b01, "after_strobe_B");

        // port independence
        load(8'h01, 8'h80, 3);
        for (int i = 0; i < 8; i++)
            read(1, {(i == 7), 1'b1}, 2'b11, $sformatf("indep_bit%0d", i));

        // rden falling edge coincident with a one-cycle strobe: load wins
        load(8'h01, 8'h00, 2);
        push(2'b01, 2'b01, "simul_first");
        bus.I_rden[0] = 1'b1;
        tick();
        bus.I_rden[0] = 1'b0;
        bus.I_strobe  = 1'b1;
        tick();
        bus.I_strobe = 1'b0;
        repeat (2) tick();
        read(0, 2'b01, 2'b01, "simul_next_is_A");

        // reset mid-sequence
        load(8'hF1, 8'hFF, 4);
        read(0, 2'b01, 2'b01, "mid_bit0");
        read(0, 2'b00, 2'b01, "mid_bit1");
        read(0, 2'b00, 2'b01, "mid_bit2");
        I_reset = 1'b1;
        tick();
        I_reset = 1'b0;
        probe(2'b00, 2'b11, "mid_reset_clear");
        read(0, 2'b00, 2'b01, "mid_reset_read");
        load(8'hF1, 8'hFF, 4);
        read(0, 2'b01, 2'b01, "mid_restrobe_A");

        // randomized rounds against the reference model
        for (int r = 0; r < 25; r++) begin
            load(8'($urandom), 8'($urandom), $urandom_range(1, 4));
            for (int i = 0, n = $urandom_range(0, 22); i < n; i++) begin
                p = $urandom_range(0, 1);
                b = m_bit(p);
                read(p, (p == 0) ? {1'b0, b} : {b, 1'b0},
                     (p == 0) ? 2'b01 : 2'b10, $sformatf("rand_r%0d_p%0d", r, p));
                m_cnt[p]++;
            end
        end

`ifdef JOYPAD_TURBO_EN
        // turbo: counter restarts at reset; phase flips every 4 cycles
        I_buttons0   = 8'h01;
        I_turbo0     = 2'b01;
        bus.I_strobe = 1'b1;
        I_reset      = 1'b1;
        tick();
        I_reset = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            b = (k < 3) ? 1'b0 : ((((k - 1) / 4) % 2) == 0);
            probe({1'b0, b}, 2'b01, $sformatf("turbo_k%0d", k));
        end
        bus.I_strobe = 1'b0;
        I_turbo0     = 2'b00;
`endif

        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_port.md
# joypad_port

Two-channel standard-controller serial port that sits directly downstream of the CPU core's $4016/$4017 GPIO outputs and feeds its `I_GPIO_data` inputs. It emulates the 8-bit parallel-in/serial-out latch of a standard pad for each port: strobe-driven parallel load, shift on each completed CPU read, and 1-fill after the eighth bit. Button inputs are asynchronous board signals and are synchronised internally. An optional turbo generator auto-toggles A/B.

## Interface
- `TURBO_HALF`, default 24'd894886: I_clock cycles per turbo half-period. Used only with turbo compiled in.
- `I_clock  in  1`: system clock, same domain as the core.
- `I_reset  in  1`: reset I_reset, synchronous, active-high; clock I_clock.
- `I_strobe  in  1`: latch strobe, driven from core `O_GPIO_data[0]`.
- `I_rden  in  2`: per-port read enables from core `O_GPIO_rden[1:0]`. Each is high during the CPU read's phy2 window.
- `I_buttons0  in  8`: port 0 buttons, async, active-high pressed. Bit order: 0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
- `I_buttons1  in  8`: port 1 buttons, same encoding.
- `I_turbo0  in  2`: port 0 turbo enables. Bit 0=A, bit 1=B. Async, active-high.
- `I_turbo1  in  2`: port 1 turbo enables, same encoding.
- `O_data  out  2`: serial bit per port, to core `I_GPIO_data[1:0]`. 1 = pressed or fill.

## Operation
- **Synchroniser:** two flops per button and turbo bit. The output is `sync_btn`.
- **Per-port state:**
  - `shreg[7:0]`
  - `last_rden`, used for edge detection.
- **Load:** while `I_strobe`=1, `shreg` <= `eff_btn` every cycle.
  - `eff_btn` = `sync_btn` after the turbo gate.
  - `O_data[n]` = `shreg[0]`, so it tracks live A.
- **Shift:** when `I_strobe`=0 and a falling edge of `I_rden[n]` occurs, `shreg` <= {1'b1, `shreg[7:1]`}.
  - A falling edge is defined as `last_rden`=1 and `I_rden[n]`=0.
  - The shift happens after the read completes, so the CPU samples the current bit first.
- **1-fill:** after 8 shifts `O_data[n]` reads 1. Further reads stay 1 until the next strobe.
- **Simultaneous events:** a strobe-high load beats a falling rden edge in the same cycle, and the edge is discarded.
- **Port independence:** ports are fully independent. A read of $4016 never shifts port 1.
- **Strobe fall:** when `I_strobe` falls, `shreg` keeps the value loaded in the final strobe-high cycle.
- **Reset:** on any cycle `I_reset`=1, all of the following clear to 0:
  - `shreg`
  - `last_rden`
  - sync flops
  - turbo counter and phase

  As a result `O_data`=2'b00. A read in progress is abandoned, and the first post-reset read returns 0 until a strobe loads.

## Timing
- **Button to `O_data`:** a button change seen at clock edge N is in `sync_btn` after edge N+1. With strobe high it is loaded at edge N+2 and visible on `O_data` after edge N+2.
- **Shift latency:** the shift is applied at the edge that samples `I_rden[n]`=0 with `last_rden`=1. The new bit is valid after that edge, well before the next CPU read.
- **Output path:** `O_data` is purely registered, with no combinational path from inputs.
- **Turbo counter:** free-running 24-bit counter. At `TURBO_HALF`-1 it wraps to 0 and toggles `phase`.

## Configuration
- **Macro:** `JOYPAD_TURBO_EN`.
- **Defined:** `eff_btn[0]` = `sync_btn[0]` & ~(`sync_turbo[0]` & `phase`), and likewise bit 1 with `sync_turbo[1]`. A held turbo button therefore reads pressed in phase 0 and released in phase 1.
- **Undefined:**
  - `eff_btn` = `sync_btn`.
  - Counter, phase and turbo synchronisers are not built.
  - `I_turbo0`/`I_turbo1` are ignored.
  - `TURBO_HALF` is unused.

## Structure
- **Package `joypad_pkg`:**
  - `button_index` enum (BTN_A=0 … BTN_RIGHT=7).
  - `localparam` `JOYPAD_BITS`=8.
  - `localparam` `JOYPAD_FILL`=1'b1.
- **Sub-module `joypad_shifter`:** instantiated twice. It contains one port's synchroniser, `shreg`, edge detect and turbo gating.
- **Top level:** owns the shared turbo counter/phase and fans it out to both instances.

## Test plan
- **Basic serial read:** reset, `I_buttons0`=8'b1000_0101, strobe 1 for 4 cycles then 0, 8 read pulses on rden[0]. Sampled bits must be 1,0,1,0,0,0,0,1; reads 9–12 must return 1.
- **Strobe held high:** `I_strobe` held 1, toggle A and issue 3 reads on port 0. `O_data[0]` must follow A with 2 cycles of latency and no shift may occur.
- **Port independence:** port 0 = 8'h01, port 1 = 8'h80; strobe, then 8 reads on port 1 only. Port 1 must give 0×7 then 1, and `O_data[0]` must stay 1 throughout.
- **Simultaneous strobe and read:** a rden falling edge in the same cycle as strobe=1 must produce no shift. The next read returns A.
- **Reset mid-sequence:** assert reset after 3 reads. `O_data` must be 00 on the next cycle, and after re-strobe the first bit must be A.
- **Turbo (macro defined, `TURBO_HALF`=4):** hold A and turbo A with strobe high. `O_data[0]` must toggle every 4 cycles.
